// File: rtl/byte_serializer_msb_pkg.sv
// Shared definitions for the serial front end and the pattern detectors.
//  - state_e          : two-state shifter FSM encoding (IDLE / SHIFT)
//  - IDLE_BIT_DEFAULT : level parked on the serial line when no word is in flight
package byte_serializer_msb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/byte_serializer_msb.sv
// byte_serializer_msb
//  Parallel-to-serial front end: takes WIDTH-bit words on a valid/ready
//  handshake and emits them MSB-first, one bit per clk, on x. A one-entry
//  hold buffer lets consecutive words stream with no gap bits.
//
// Ports
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-low
//  din          in   WIDTH  parallel word, MSB sent first
//  din_valid    in   1      din is valid this cycle
//  din_ready    out  1      block can accept din this cycle
//  x            out  1      serial bit, registered (IDLE_BIT when idle)
//  x_valid      out  1      x carries a data bit
//  frame_start  out  1      x carries the MSB of a word
//  busy         out  1      shifter active or hold buffer full
//
// Handshake: a word is transferred on a rising clk edge where
// din_valid & din_ready are both high. din_ready depends only on registers
// (and reset), never on din_valid; the source must keep din stable while
// din_valid is high and din_ready is low.
module byte_serializer_msb
  import byte_serializer_msb_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;      // remaining bits, next one at the MSB
  logic [CW-1:0]    cnt_q;        // bits still to emit after the one on x
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             x_q;
  logic             x_valid_q;
  logic             frame_start_q;

  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;
  logic             hold_wr;

  assign din_ready   = reset & ~hold_full_q;
  assign accept      = din_valid & din_ready;
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == S_SHIFT) | hold_full_q;

  // Decide where the next word comes from. On the last bit of a word the
  // held word has priority; din_ready was low then, so no accept collides.
  always_comb begin
    load_en   = 1'b0;
    load_word = din;
    hold_wr   = 1'b0;
    case (state_q)
      S_IDLE: load_en = accept;
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (hold_full_q) begin
            load_en   = 1'b1;
            load_word = hold_q;
          end else begin
            load_en = accept;
          end
        end else begin
          hold_wr = accept;
        end
      end
      default: load_en = 1'b0;
    endcase
  end

  // Shifter FSM with registered outputs. Datapath registers (shreg, cnt,
  // hold) are not reset: they are always written before being observed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      hold_full_q   <= 1'b0;
      x_q           <= IDLE_BIT;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (hold_wr) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end else if (load_en && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (load_en) begin
        x_q           <= load_word[WIDTH-1];
        shreg_q       <= load_word << 1;
        cnt_q         <= CNT_MAX;
        x_valid_q     <= 1'b1;
        frame_start_q <= 1'b1;
        state_q       <= S_SHIFT;
      end else if (state_q == S_SHIFT && cnt_q != '0) begin
        x_q           <= shreg_q[WIDTH-1];
        shreg_q       <= shreg_q << 1;
        cnt_q         <= cnt_q - 1'b1;
        frame_start_q <= 1'b0;
      end else begin
        state_q       <= S_IDLE;
        x_q           <= IDLE_BIT;
        x_valid_q     <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer_msb.sv
// Directed bench for byte_serializer_msb: an 8-bit, idle-high instance and a
// 4-bit, idle-low instance sharing clock and reset.
module tb_byte_serializer_msb;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // WIDTH=8, IDLE_BIT=1 instance
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, x_valid, frame_start, busy;

  // WIDTH=4, IDLE_BIT=0 instance
  logic [3:0] din4;
  logic       din_valid4;
  logic       din_ready4, x4, x_valid4, frame_start4, busy4;

  int total = 0;
  int bad   = 0;

  byte_serializer_msb #(.WIDTH(8), .IDLE_BIT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid),
    .frame_start(frame_start), .busy(busy)
  );

  byte_serializer_msb #(.WIDTH(4), .IDLE_BIT(1'b0)) u_dut4 (
    .clk(clk), .reset(reset), .din(din4), .din_valid(din_valid4),
    .din_ready(din_ready4), .x(x4), .x_valid(x_valid4),
    .frame_start(frame_start4), .busy(busy4)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] t2_bits;
  logic [23:0] t3_bits;
  logic [7:0]  t1_bits;
  logic [3:0]  t6_bits;

  initial begin
    reset      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    din4       = '0;
    din_valid4 = 1'b0;

    // reset state
    step();
    step();
    chk("rst x", x, 1'b1);
    chk("rst x_valid", x_valid, 1'b0);
    chk("rst frame_start", frame_start, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst din_ready", din_ready, 1'b0);
    chk("rst x4", x4, 1'b0);
    chk("rst x_valid4", x_valid4, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst rel din_ready", din_ready, 1'b1);

    // T1 single word 8'h39
    t1_bits   = 8'h39;
    din       = 8'h39;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t1 x[%0d]", i), x, t1_bits[8-i]);
      chk($sformatf("t1 x_valid[%0d]", i), x_valid, 1'b1);
      chk($sformatf("t1 frame_start[%0d]", i), frame_start, (i == 1) ? 1'b1 : 1'b0);
      step();
    end
    chk("t1 idle x", x, 1'b1);
    chk("t1 idle x_valid", x_valid, 1'b0);
    chk("t1 idle busy", busy, 1'b0);

    // T2 back-to-back F3 then 9F, no gap
    t2_bits   = 16'hF39F;
    din       = 8'hF3;
    din_valid = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      if (i == 1) begin
        din = 8'h9F;
        chk("t2 ready for second", din_ready, 1'b1);
      end
      if (i == 2) begin
        din_valid = 1'b0;
        chk("t2 ready held", din_ready, 1'b0);
      end
      chk($sformatf("t2 x[%0d]", i), x, t2_bits[16-i]);
      chk($sformatf("t2 x_valid[%0d]", i), x_valid, 1'b1);
      chk($sformatf("t2 frame_start[%0d]", i), frame_start,
          (i == 1 || i == 9) ? 1'b1 : 1'b0);
      step();
    end
    chk("t2 idle x", x, 1'b1);
    chk("t2 idle x_valid", x_valid, 1'b0);
    chk("t2 idle busy", busy, 1'b0);

    // T3 backpressure: C5, 3A, 81 offered continuously
    t3_bits   = 24'hC53A81;
    din       = 8'hC5;
    din_valid = 1'b1;
    step();
    for (int i = 1; i <= 24; i++) begin
      if (i == 1)  din = 8'h3A;
      if (i == 2)  din = 8'h81;
      if (i == 10) din_valid = 1'b0;
      chk($sformatf("t3 ready[%0d]", i), din_ready,
          (i == 1 || i == 9 || i >= 17) ? 1'b1 : 1'b0);
      chk($sformatf("t3 x[%0d]", i), x, t3_bits[24-i]);
      chk($sformatf("t3 x_valid[%0d]", i), x_valid, 1'b1);
      chk($sformatf("t3 frame_start[%0d]", i), frame_start,
          (i == 1 || i == 9 || i == 17) ? 1'b1 : 1'b0);
      chk($sformatf("t3 busy[%0d]", i), busy, 1'b1);
      step();
    end
    chk("t3 idle x", x, 1'b1);
    chk("t3 idle x_valid", x_valid, 1'b0);

    // T4 reset mid-word: A5 shifting, 3C in hold
    din       = 8'hA5;
    din_valid = 1'b1;
    step();
    din = 8'h3C;
    step();
    din_valid = 1'b0;
    chk("t4 hold full ready", din_ready, 1'b0);
    chk("t4 x[2]", x, 1'b0);
    step();
    chk("t4 x[3]", x, 1'b1);
    step();
    chk("t4 x[4]", x, 1'b0);
    reset = 1'b0;
    step();
    chk("t4 x", x, 1'b1);
    chk("t4 x_valid", x_valid, 1'b0);
    chk("t4 busy", busy, 1'b0);
    chk("t4 frame_start", frame_start, 1'b0);
    reset = 1'b1;
    #1;
    chk("t4 din_ready", din_ready, 1'b1);
    step();
    chk("t4 after x_valid", x_valid, 1'b0);
    chk("t4 after busy", busy, 1'b0);

    // T5 idle for 20 clocks
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("t5 x[%0d]", i), x, 1'b1);
      chk($sformatf("t5 x_valid[%0d]", i), x_valid, 1'b0);
      chk($sformatf("t5 din_ready[%0d]", i), din_ready, 1'b1);
    end

    // T6 WIDTH=4, IDLE_BIT=0: 4'h9
    chk("t6 idle x4", x4, 1'b0);
    t6_bits    = 4'h9;
    din4       = 4'h9;
    din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t6 x4[%0d]", i), x4, t6_bits[4-i]);
      chk($sformatf("t6 x_valid4[%0d]", i), x_valid4, 1'b1);
      chk($sformatf("t6 frame_start4[%0d]", i), frame_start4, (i == 1) ? 1'b1 : 1'b0);
      step();
    end
    chk("t6 end x4", x4, 1'b0);
    chk("t6 end x_valid4", x_valid4, 1'b0);
    chk("t6 end busy4", busy4, 1'b0);
    chk("t6 end din_ready4", din_ready4, 1'b1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
